// File: rtl/dpc_win_pkg.sv
// dpc_win_pkg
// Shared definitions for the 3x3 dead-pixel-correction window generator:
// FSM state encoding, window tap numbering and frame counter widths.
// Tap k of a window is row-major: TAP_TL is top-left, TAP_C the centre,
// TAP_BR bottom-right.
package dpc_win_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int WIN_TAPS = 9;

    localparam int TAP_TL = 0;
    localparam int TAP_TC = 1;
    localparam int TAP_TR = 2;
    localparam int TAP_ML = 3;
    localparam int TAP_C  = 4;
    localparam int TAP_MR = 5;
    localparam int TAP_BL = 6;
    localparam int TAP_BC = 7;
    localparam int TAP_BR = 8;

    // Row counter covers IMG_H up to 4096, column counter IMG_W up to 1024.
    localparam int ROW_W = 12;
    localparam int COL_W = 10;

endpackage

// File: rtl/dpc_line_delay.sv
// dpc_line_delay
// Circular line delay of exactly DEPTH advances built on one RAM.
// dout presents the din value written DEPTH advances earlier; it only moves
// when en is high.
// The RAM holds DEPTH-1 entries and the registered read port supplies the
// final stage of delay, so RAM plus read register add up to DEPTH.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (pointer only; RAM is not cleared)
//   en     advance enable
//   din    value entering the delay
//   dout   value that entered DEPTH advances ago
import dpc_win_pkg::*;

module dpc_line_delay #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 640
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int RAM_D = DEPTH - 1;
    localparam int AW    = (RAM_D > 1) ? $clog2(RAM_D) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(RAM_D - 1);

    logic [WIDTH-1:0] mem [RAM_D];
    logic [AW-1:0]    ptr_reg;
    logic [WIDTH-1:0] dout_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_reg <= '0;
        end else if (en) begin
            ptr_reg <= (ptr_reg == PTR_LAST) ? '0 : ptr_reg + AW'(1);
        end
    end

    // Read-first: the old entry leaves before the new one overwrites it.
    // Left without reset so the RAM and its output register map onto block RAM;
    // whatever it holds after reset only feeds taps that are never emitted.
    always_ff @(posedge clk) begin
        if (en) begin
            dout_reg     <= mem[ptr_reg];
            mem[ptr_reg] <= din;
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/dpc_window_3x3.sv
// dpc_window_3x3
// Streaming 3x3 neighbourhood generator for dead-pixel correction.
// Accepts a raster pixel stream and, for every pixel, emits one 3x3 window
// centred on it, IMG_W+1 advances later. Taps outside the image are
// substituted using the centre row/column counters.
// At the end of a frame it flushes IMG_W+1 zero pixels with in_ready low so
// the last windows drain out.
// Build option: DPC_WIN_REPLICATE_EN defined -> out-of-image taps replicate the
// nearest in-image pixel; undefined -> out-of-image taps are 0.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   data_in carries a pixel
//   in_ready   pixel accepted when in_valid && in_ready
//   data_in    raster-order pixel
//   out_valid  one-cycle pulse per window
//   win_out    tap k at [k*WIDTH +: WIDTH], row-major, tap 4 = centre
//   out_row    centre row
//   out_col    centre column
//   out_eof    marks the window centred at (IMG_H-1, IMG_W-1)
import dpc_win_pkg::*;

module dpc_window_3x3 #(
    parameter int WIDTH = 16,
    parameter int IMG_W = 640,
    parameter int IMG_H = 512
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          data_in,
    output logic                      out_valid,
    output logic [WIN_TAPS*WIDTH-1:0] win_out,
    output logic [ROW_W-1:0]          out_row,
    output logic [COL_W-1:0]          out_col,
    output logic                      out_eof
);

    localparam int CNT_W = COL_W + 1;
    localparam logic [CNT_W-1:0] FILL_MAX   = CNT_W'(IMG_W + 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(IMG_W);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_W - 1);

    state_t           state_reg, state_next;
    logic [ROW_W-1:0] in_row_reg, cen_row_reg;
    logic [COL_W-1:0] in_col_reg, cen_col_reg;
    logic [CNT_W-1:0] fill_reg;       // advances this frame, saturating at IMG_W+1
    logic [CNT_W-1:0] flush_cnt_reg;

    logic             advance, emit, last_in, flush_done;
    logic [WIDTH-1:0] px;
    logic [WIDTH-1:0] ld0_out, ld1_out;

    logic                      out_valid_reg, out_eof_reg;
    logic [WIN_TAPS*WIDTH-1:0] win_reg, win_next;
    logic [ROW_W-1:0]          out_row_reg;
    logic [COL_W-1:0]          out_col_reg;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    assign advance    = (state_reg == FLUSH) || in_valid;
    assign px         = (state_reg == RUN) ? data_in : '0;
    assign last_in    = (in_row_reg == ROW_LAST) && (in_col_reg == COL_LAST);
    assign emit       = advance && (fill_reg == FILL_MAX);
    assign flush_done = (state_reg == FLUSH) && (flush_cnt_reg == FLUSH_LAST);

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        case (state_reg)
            RUN: begin
                in_ready = 1'b1;
                if (in_valid && last_in) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_done) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= RUN;
            in_row_reg    <= '0;
            in_col_reg    <= '0;
            cen_row_reg   <= '0;
            cen_col_reg   <= '0;
            fill_reg      <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (advance) begin
                if (flush_done) begin
                    fill_reg <= '0;
                end else if (fill_reg != FILL_MAX) begin
                    fill_reg <= fill_reg + CNT_W'(1);
                end

                // Input position holds at the last pixel through the flush.
                if (state_reg == RUN) begin
                    if (in_col_reg != COL_LAST) begin
                        in_col_reg <= in_col_reg + COL_W'(1);
                    end else if (!last_in) begin
                        in_col_reg <= '0;
                        in_row_reg <= in_row_reg + ROW_W'(1);
                    end
                end else if (flush_done) begin
                    in_col_reg <= '0;
                    in_row_reg <= '0;
                end

                if (state_reg == FLUSH) begin
                    flush_cnt_reg <= flush_done ? '0 : flush_cnt_reg + CNT_W'(1);
                end

                // The final flush advance emits (IMG_H-1, IMG_W-1); rewind there.
                if (emit) begin
                    if (flush_done) begin
                        cen_row_reg <= '0;
                        cen_col_reg <= '0;
                    end else if (cen_col_reg == COL_LAST) begin
                        cen_col_reg <= '0;
                        cen_row_reg <= cen_row_reg + ROW_W'(1);
                    end else begin
                        cen_col_reg <= cen_col_reg + COL_W'(1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Line delays: ld0 yields the row above the incoming pixel, ld1 two rows
    // ------------------------------------------------------------------
    dpc_line_delay #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_ld0 (
        .clk   (clk),
        .reset (reset),
        .en    (advance),
        .din   (px),
        .dout  (ld0_out)
    );

    dpc_line_delay #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_ld1 (
        .clk   (clk),
        .reset (reset),
        .en    (advance),
        .din   (ld0_out),
        .dout  (ld1_out)
    );

    // ------------------------------------------------------------------
    // Window columns. The incoming column is used directly as the right
    // column, so the registered window lines up with this advance.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] new_col    [3];
    logic [WIDTH-1:0] hist_l_reg [3];
    logic [WIDTH-1:0] hist_c_reg [3];
    logic [WIDTH-1:0] raw        [3][3];

    assign new_col[0] = ld1_out;
    assign new_col[1] = ld0_out;
    assign new_col[2] = px;

    logic top_out, bot_out, left_out, right_out;
    assign top_out   = (cen_row_reg == '0);
    assign bot_out   = (cen_row_reg == ROW_LAST);
    assign left_out  = (cen_col_reg == '0);
    assign right_out = (cen_col_reg == COL_LAST);

    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                hist_l_reg[gi] <= '0;
                hist_c_reg[gi] <= '0;
            end else if (advance) begin
                hist_l_reg[gi] <= hist_c_reg[gi];
                hist_c_reg[gi] <= new_col[gi];
            end
        end

        assign raw[gi][0] = hist_l_reg[gi];
        assign raw[gi][1] = hist_c_reg[gi];
        assign raw[gi][2] = new_col[gi];

        for (genvar gj = 0; gj < 3; gj++) begin : g_col
            logic row_out, col_out;
            assign row_out = ((gi == 0) && top_out) || ((gi == 2) && bot_out);
            assign col_out = ((gj == 0) && left_out) || ((gj == 2) && right_out);
`ifdef DPC_WIN_REPLICATE_EN
            // Row substitution first, then column, so corners pick the corner pixel.
            assign win_next[(gi*3+gj)*WIDTH +: WIDTH] =
                row_out ? (col_out ? raw[1][1]  : raw[1][gj])
                        : (col_out ? raw[gi][1] : raw[gi][gj]);
`else
            assign win_next[(gi*3+gj)*WIDTH +: WIDTH] =
                (row_out || col_out) ? '0 : raw[gi][gj];
`endif
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_reg <= 1'b0;
            out_eof_reg   <= 1'b0;
            win_reg       <= '0;
            out_row_reg   <= '0;
            out_col_reg   <= '0;
        end else begin
            out_valid_reg <= emit;
            out_eof_reg   <= emit && flush_done;
            if (emit) begin
                win_reg     <= win_next;
                out_row_reg <= cen_row_reg;
                out_col_reg <= cen_col_reg;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_eof   = out_eof_reg;
    assign win_out   = win_reg;
    assign out_row   = out_row_reg;
    assign out_col   = out_col_reg;

endmodule
